// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the servo ramp/PWM block.
package servo_pkg;

  // Defaults for a 100 MHz system clock.
  localparam int unsigned PWM_PERIOD_CYC = 2_000_000;  // 20 ms frame
  localparam int unsigned MIN_PULSE_CYC  = 100_000;    // 1 ms pulse at pos 0
  localparam int unsigned STEP_CYC       = 392;        // pulse cycles per pos LSB

  // Frame counter and pulse-width datapath width.
  localparam int unsigned PWM_W = 21;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DOWN
  } ramp_state_t;

endpackage

// File: rtl/servo_pwm_core.sv
// Frame counter, per-frame width latch and pulse compare for the servo PWM.
module servo_pwm_core
  import servo_pkg::*;
#(
  parameter int unsigned      PERIOD_CYC  = PWM_PERIOD_CYC,
  parameter logic [PWM_W-1:0] RESET_WIDTH = PWM_W'(MIN_PULSE_CYC + 128 * STEP_CYC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] width,
  input  logic             enable,
  output logic             pwm,
  output logic             frame_start
);

  logic [PWM_W-1:0] count_q;
  logic [PWM_W-1:0] width_q;
  logic             pwm_q;
  logic             frame_start_q;
  logic             count_zero;
  logic             count_last;
  logic [PWM_W-1:0] cur_width;

  assign count_zero = (count_q == '0);
  assign count_last = (count_q == PWM_W'(PERIOD_CYC - 1));
  // At count 0 the new width is being latched, so compare against it directly.
  assign cur_width  = count_zero ? width : width_q;

  // Counter, width latch and registered outputs (one cycle behind the count).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q       <= '0;
      width_q       <= RESET_WIDTH;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (!enable || count_last) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
      if (count_zero) begin
        width_q <= width;
      end
      pwm_q         <= enable && (count_q < cur_width);
      frame_start_q <= enable && count_zero;
    end
  end

  assign pwm         = pwm_q;
  assign frame_start = frame_start_q;

endmodule

// File: rtl/servo_ramp_pwm.sv
// Servo driver: rate-limited position ramp toward a target, feeding a framed PWM core.
module servo_ramp_pwm #(
  parameter int unsigned PWM_PERIOD_CYC = servo_pkg::PWM_PERIOD_CYC,
  parameter int unsigned MIN_PULSE_CYC  = servo_pkg::MIN_PULSE_CYC,
  parameter int unsigned STEP_CYC       = servo_pkg::STEP_CYC,
  parameter int unsigned MAX_STEP       = 16,
  parameter logic [7:0]  RESET_POS      = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_5hz,
  input  logic       enable,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       pwm,
  output logic [7:0] pos,
  output logic       busy,
  output logic       frame_start
);

  import servo_pkg::*;

  logic             tick_q;
  logic             primed_q;
  logic             step;
  logic [7:0]       tgt_q;
  logic [7:0]       pos_q;
  ramp_state_t      state_q;
  logic [8:0]       pos_up;
  logic [8:0]       pos_dn;
  logic [7:0]       up_val;
  logic [7:0]       dn_val;
  logic [PWM_W-1:0] width;

  // primed_q masks the first cycle after reset so a tick already high at
  // release is not mistaken for a rising edge.
  assign step = primed_q && tick_5hz && !tick_q;

  // Tick edge register and target capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q   <= 1'b0;
      primed_q <= 1'b0;
      tgt_q    <= RESET_POS;
    end else begin
      tick_q   <= tick_5hz;
      primed_q <= 1'b1;
      if (target_valid) begin
        tgt_q <= target;
      end
    end
  end

  // 9-bit step arithmetic: clamp at the target, never wrap past 0 or 255.
  assign pos_up = {1'b0, pos_q} + 9'(MAX_STEP);
  assign pos_dn = {1'b0, pos_q} - 9'(MAX_STEP);
  assign up_val = (pos_up > {1'b0, tgt_q}) ? tgt_q : pos_up[7:0];
  assign dn_val = ({1'b0, pos_q} < ({1'b0, tgt_q} + 9'(MAX_STEP))) ? tgt_q : pos_dn[7:0];

  // Ramp FSM: direction from tgt_q vs pos, one bounded move per enabled step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HOLD;
      pos_q   <= RESET_POS;
    end else begin
      if (step && enable) begin
        // Guards cover a target that changed in the cycle before the step.
        unique case (state_q)
          UP:      if (tgt_q > pos_q) pos_q <= up_val;
          DOWN:    if (tgt_q < pos_q) pos_q <= dn_val;
          default: ;
        endcase
      end
      if (tgt_q > pos_q) begin
        state_q <= UP;
      end else if (tgt_q < pos_q) begin
        state_q <= DOWN;
      end else begin
        state_q <= HOLD;
      end
    end
  end

  assign width = PWM_W'(MIN_PULSE_CYC) + PWM_W'(STEP_CYC) * PWM_W'(pos_q);
  assign pos   = pos_q;
  assign busy  = (pos_q != tgt_q);

  servo_pwm_core #(
    .PERIOD_CYC  (PWM_PERIOD_CYC),
    .RESET_WIDTH (PWM_W'(MIN_PULSE_CYC + RESET_POS * STEP_CYC))
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .width       (width),
    .enable      (enable),
    .pwm         (pwm),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Directed self-checking bench for servo_ramp_pwm with a shortened frame.
module tb_servo_ramp_pwm;

  // Scaled timing: period 1000, width = 100 + 3*pos.
  localparam int unsigned PERIOD = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_5hz = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] target = 8'd0;
  logic       target_valid = 1'b0;
  logic       pwm;
  logic [7:0] pos;
  logic       busy;
  logic       frame_start;

  int total = 0;
  int bad = 0;

  int frame_cnt = 0;
  int cur_hi = 0;
  int cur_per = 0;
  int last_hi = 0;
  int last_per = 0;

  servo_ramp_pwm #(
    .PWM_PERIOD_CYC (PERIOD),
    .MIN_PULSE_CYC  (100),
    .STEP_CYC       (3),
    .MAX_STEP       (16),
    .RESET_POS      (8'd128)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_5hz     (tick_5hz),
    .enable       (enable),
    .target       (target),
    .target_valid (target_valid),
    .pwm          (pwm),
    .pos          (pos),
    .busy         (busy),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // Per-frame high-time and period measurement, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_start) begin
      last_hi   <= cur_hi;
      last_per  <= cur_per;
      cur_hi    <= pwm ? 1 : 0;
      cur_per   <= 1;
      frame_cnt <= frame_cnt + 1;
    end else begin
      cur_hi  <= cur_hi + (pwm ? 1 : 0);
      cur_per <= cur_per + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    int start;
    int k;
    start = frame_cnt;
    k = 0;
    while ((frame_cnt < start + n) && (k < 5 * PERIOD)) begin
      @(posedge clk);
      k++;
    end
    check_eq("frame_wait", frame_cnt - start, n);
  endtask

  task automatic set_target(input logic [7:0] v);
    @(posedge clk);
    #1 target = v;
    target_valid = 1'b1;
    @(posedge clk);
    #1 target_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // One divider rising edge; returns on a falling edge ready for sampling.
  task automatic do_tick();
    @(posedge clk);
    #1 tick_5hz = 1'b1;
    repeat (2) @(posedge clk);
    #1 tick_5hz = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with tick already high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pwm", pwm, 0);
    check_eq("rst_fs", frame_start, 0);
    check_eq("rst_pos", pos, 128);
    check_eq("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("no_step_high_tick", pos, 128);
    #1 tick_5hz = 1'b0;

    // First frame after release.
    wait_frames(2);
    check_eq("first_hi", last_hi, 484);
    check_eq("first_per", last_per, PERIOD);
    check_eq("first_busy", busy, 0);

    // Ramp up to 200; first step lands mid-frame.
    set_target(8'd200);
    do_tick();
    check_eq("ramp_144", pos, 144);
    check_eq("busy_144", busy, 1);
    wait_frames(1);
    check_eq("midframe_old_hi", last_hi, 484);
    wait_frames(1);
    check_eq("next_frame_hi", last_hi, 532);
    do_tick();
    check_eq("ramp_160", pos, 160);
    do_tick();
    check_eq("ramp_176", pos, 176);
    do_tick();
    check_eq("ramp_192", pos, 192);
    check_eq("busy_192", busy, 1);
    do_tick();
    check_eq("ramp_200", pos, 200);
    check_eq("busy_200", busy, 0);
    do_tick();
    check_eq("hold_200", pos, 200);

    // Ramp down to 10, then to 0 without wrapping.
    set_target(8'd10);
    do_tick();
    check_eq("down_184", pos, 184);
    for (int i = 0; i < 11; i++) do_tick();
    check_eq("down_10", pos, 10);
    set_target(8'd0);
    do_tick();
    check_eq("down_0", pos, 0);
    check_eq("busy_0", busy, 0);
    do_tick();
    check_eq("floor_0", pos, 0);

    // Target strobe coincident with the tick edge uses the old target.
    @(posedge clk);
    #1 tick_5hz = 1'b1;
    target = 8'd100;
    target_valid = 1'b1;
    @(posedge clk);
    #1 target_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 tick_5hz = 1'b0;
    @(negedge clk);
    check_eq("same_cycle_pos", pos, 0);
    check_eq("same_cycle_busy", busy, 1);
    repeat (2) @(posedge clk);
    do_tick();
    check_eq("new_tgt_step", pos, 16);

    // Freeze for three ticks.
    @(posedge clk);
    #1 enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check_eq("frozen_pos", pos, 16);
      check_eq("frozen_pwm", pwm, 0);
      check_eq("frozen_fs", frame_start, 0);
    end

    // Re-enable: fresh frame with width from pos 16.
    @(posedge clk);
    #1 enable = 1'b1;
    wait_frames(2);
    check_eq("reenable_hi", last_hi, 148);
    check_eq("reenable_per", last_per, PERIOD);

    // Asynchronous reset mid-pulse.
    @(posedge clk);
    #2 check_eq("pwm_before_rst", pwm, 1);
    rst = 1'b0;
    #1 check_eq("rst_async_pwm", pwm, 0);
    check_eq("rst_async_pos", pos, 128);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_pos", pos, 128);
    check_eq("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_ramp_pwm.md
SERVO_RAMP_PWM -- requirements
Module: servo_ramp_pwm

Interface
REQ-001 Parameters SHALL be:
- PWM_PERIOD_CYC, 2_000_000: 20 ms frame at 100 MHz.
- MIN_PULSE_CYC, 100_000: 1 ms pulse at pos 0.
- STEP_CYC, 392: pulse cycles added per pos LSB.
- MAX_STEP, 16: max pos change per tick.
- RESET_POS, 8'd128: pos and target value after reset.
REQ-002 Ports SHALL be, clock and reset first:
- clk, in, 1: single system clock, 100 MHz.
- rst, in, 1: asynchronous, active-low reset.
- tick_5hz, in, 1: 5 Hz square wave from the clk-domain divider; only its rising edge is used.
- enable, in, 1: run/freeze.
- target, in, 8: requested position, 0..255.
- target_valid, in, 1: load strobe for target.
- pwm, out, 1: servo drive.
- pos, out, 8: current position.
- busy, out, 1: high while pos != captured target.
- frame_start, out, 1: one-cycle pulse at each PWM period start.

Function
REQ-003 tick_5hz SHALL be registered once; a step event SHALL be a 1-cycle pulse when the registered value is 0 and the current value is 1 (one step per divider rising edge, no synchronizer, same clock domain).
REQ-004 target_valid=1 SHALL load target into tgt_q on the next clk edge, regardless of enable; there is no backpressure.
REQ-005 The ramp FSM SHALL have states HOLD, UP and DOWN, evaluated every cycle from tgt_q vs pos:
- Go to UP if tgt_q > pos.
- Go to DOWN if tgt_q < pos.
- Otherwise go to HOLD.
REQ-006 On a step event with enable=1:
- UP SHALL set pos to min(pos+MAX_STEP, tgt_q).
- DOWN SHALL set pos to max(pos-MAX_STEP, tgt_q).
- HOLD SHALL leave pos unchanged.
- Arithmetic SHALL be done at 9 bits, so pos never wraps past 0 or 255 and never overshoots tgt_q.
REQ-007 When target_valid and a step event occur in the same cycle, the step SHALL use the old tgt_q; the new target takes effect from the next step event.
REQ-008 busy SHALL be combinational (pos != tgt_q).
REQ-009 The frame counter SHALL be 21 bits and count 0..PWM_PERIOD_CYC-1, then wrap to 0; frame_start SHALL be high in the cycle the count is 0.
REQ-010 Pulse width SHALL be MIN_PULSE_CYC + pos*STEP_CYC (21 bits, max 199_960 cycles), latched into width_q only when the count is 0; pos changes mid-frame SHALL NOT alter the current pulse.
REQ-011 pwm SHALL be registered: 1 while count < width_q, else 0; output latency is 1 cycle after the count.
REQ-012 When enable=0:
- Frame counter held at 0.
- pwm=0 and frame_start=0.
- pos frozen; step events ignored.
REQ-013 On an enable 0->1 transition, a new frame SHALL start at count 0 with width_q reloaded from pos.

Reset
REQ-014 While rst=0, outputs SHALL be: pwm=0, frame_start=0, pos=RESET_POS, busy=0.
REQ-015 While rst=0, internal state SHALL be: tgt_q=RESET_POS, FSM=HOLD, counter=0, width_q=MIN_PULSE_CYC+RESET_POS*STEP_CYC, tick register=0.
REQ-016 Reset assertion mid-pulse SHALL drop pwm immediately (asynchronous); deassertion SHALL take effect on the next clk edge.
REQ-017 If tick_5hz is already high at reset release, no step event SHALL be generated until it goes low and high again.

Structure
REQ-018 Package servo_pkg SHALL hold:
- The ramp_state_t enum {HOLD, UP, DOWN}.
- PWM_PERIOD_CYC, MIN_PULSE_CYC, STEP_CYC and the 21-bit width localparam.
REQ-019 The frame counter, width latch and compare SHALL be one sub-module, servo_pwm_core (inputs: width, enable; outputs: pwm, frame_start); the ramp FSM SHALL remain in the top level.

Verification
REQ-020 Reset release with enable=1 -> first pwm high time = 150_176 cycles, period 2_000_000 cycles, busy=0.
REQ-021 target=200 strobed, then 5 tick edges -> pos sequence 144, 160, 176, 192, 200; busy falls after the 5th step.
REQ-022 target=0 from pos 10, tick edge -> pos 0, no wrap; a further tick leaves pos at 0.
REQ-023 A step occurring mid-frame -> the current pulse keeps its old width; the next frame uses the new width (e.g. 100_000+144*392 = 156_448).
REQ-024 target_valid in the same cycle as a tick edge -> that step uses the old target; enable=0 for 3 ticks -> pos unchanged and pwm=0.
REQ-025 rst pulled low mid-pulse -> pwm=0 within the same cycle; after release, pos=128.
